// File: rtl/spi_master_core.sv
// SPI mode-0 initiator: MSB-first WORD_SIZE-bit words, single or burst (cs held low),
// with a ready/start host handshake and a one-cycle done strobe.
module spi_master_core #(
  parameter int WORD_SIZE = 8,
  parameter int CLK_DIV   = 2
) (
  input  logic                 clk_i,
  input  logic                 nreset_i,
  input  logic                 start_i,
  input  logic                 cont_i,
  input  logic [WORD_SIZE-1:0] data_tx_i,
  output logic                 ready_o,
  output logic [WORD_SIZE-1:0] data_rx_o,
  output logic                 done_o,
  output logic                 sck_o,
  output logic                 cs_o,
  output logic                 sdo_o,
  input  logic                 sdi_i
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(WORD_SIZE) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_SIZE - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_GAP   = 3'd4,
    ST_BURST = 3'd5
  } state_t;

  state_t                 state_r, state_s;
  logic [DIV_W-1:0]       div_cnt_r, div_cnt_s;
  logic [BIT_W-1:0]       bit_cnt_r, bit_cnt_s;
  logic [WORD_SIZE-1:0]   tx_r, tx_s;
  logic [WORD_SIZE-1:0]   rx_r, rx_s;
  logic [WORD_SIZE-1:0]   data_rx_r, data_rx_s;
  logic                   cont_r, cont_s;
  logic                   sck_r, sck_s;
  logic                   cs_r, cs_s;
  logic                   ready_r, ready_s;
  logic                   done_r, done_s;

  logic tick_s;
  logic accept_s;
  logic rise_s;
  logic fall_s;
  logic last_s;

  // The first rising edge of a word is the SETUP->SHIFT transition itself.
  assign tick_s   = (div_cnt_r == DIV_LAST);
  assign accept_s = start_i && ready_r;
  assign rise_s   = tick_s && ((state_r == ST_SETUP) || ((state_r == ST_SHIFT) && !sck_r));
  assign fall_s   = tick_s && (state_r == ST_SHIFT) && sck_r;
  assign last_s   = fall_s && (bit_cnt_r == BIT_LAST);

  // State register.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_s = ST_SETUP;
        else          state_s = ST_IDLE;
      end
      ST_SETUP: begin
        if (tick_s) state_s = ST_SHIFT;
        else        state_s = ST_SETUP;
      end
      ST_SHIFT: begin
        if (last_s) state_s = cont_r ? ST_BURST : ST_HOLD;
        else        state_s = ST_SHIFT;
      end
      ST_HOLD: begin
        if (tick_s) state_s = ST_GAP;
        else        state_s = ST_HOLD;
      end
      ST_GAP: begin
        if (tick_s) state_s = ST_IDLE;
        else        state_s = ST_GAP;
      end
      ST_BURST: begin
        if (accept_s) state_s = ST_SETUP;
        else          state_s = ST_BURST;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values of datapath and registered outputs.
  always_comb begin
    div_cnt_s = '0;
    bit_cnt_s = bit_cnt_r;
    tx_s      = tx_r;
    rx_s      = rx_r;
    cont_s    = cont_r;
    sck_s     = sck_r;
    cs_s      = 1'b1;
    ready_s   = 1'b0;
    done_s    = 1'b0;
    data_rx_s = data_rx_r;

    case (state_r)
      ST_SETUP, ST_SHIFT, ST_HOLD, ST_GAP: begin
        if (tick_s) div_cnt_s = '0;
        else        div_cnt_s = div_cnt_r + DIV_W'(1);
      end
      default: div_cnt_s = '0;
    endcase

    if (accept_s) begin
      tx_s      = data_tx_i;
      cont_s    = cont_i;
      bit_cnt_s = '0;
    end else if (fall_s) begin
      tx_s      = {tx_r[WORD_SIZE-2:0], 1'b0};
      bit_cnt_s = bit_cnt_r + BIT_W'(1);
    end else begin
      tx_s      = tx_r;
      bit_cnt_s = bit_cnt_r;
    end

    if (rise_s) begin
      rx_s  = {rx_r[WORD_SIZE-2:0], sdi_i};
      sck_s = 1'b1;
    end else if (fall_s) begin
      rx_s  = rx_r;
      sck_s = 1'b0;
    end else begin
      rx_s  = rx_r;
      sck_s = sck_r;
    end

    case (state_s)
      ST_IDLE:  begin cs_s = 1'b1; ready_s = 1'b1; end
      ST_GAP:   begin cs_s = 1'b1; ready_s = 1'b0; end
      ST_BURST: begin cs_s = 1'b0; ready_s = 1'b1; end
      default:  begin cs_s = 1'b0; ready_s = 1'b0; end
    endcase

    // rx is already complete here: the last rise precedes the last fall by CLK_DIV cycles.
    if (((state_r == ST_HOLD) && (state_s == ST_GAP)) ||
        ((state_r == ST_SHIFT) && (state_s == ST_BURST))) begin
      done_s    = 1'b1;
      data_rx_s = rx_r;
    end else begin
      done_s    = 1'b0;
      data_rx_s = data_rx_r;
    end
  end

  // Datapath and output flops; every pin is driven straight from a flop.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      div_cnt_r <= '0;
      bit_cnt_r <= '0;
      tx_r      <= '0;
      rx_r      <= '0;
      cont_r    <= 1'b0;
      sck_r     <= 1'b0;
      cs_r      <= 1'b1;
      ready_r   <= 1'b1;
      done_r    <= 1'b0;
      data_rx_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_s;
      bit_cnt_r <= bit_cnt_s;
      tx_r      <= tx_s;
      rx_r      <= rx_s;
      cont_r    <= cont_s;
      sck_r     <= sck_s;
      cs_r      <= cs_s;
      ready_r   <= ready_s;
      done_r    <= done_s;
      data_rx_r <= data_rx_s;
    end
  end

  assign ready_o   = ready_r;
  assign data_rx_o = data_rx_r;
  assign done_o    = done_r;
  assign sck_o     = sck_r;
  assign cs_o      = cs_r;
  assign sdo_o     = tx_r[WORD_SIZE-1];

endmodule
